// File: rtl/Types.sv
// Shared types for the tagged vector normalizer: tagged Q8.8 input vectors and
// tagged Q1.14 unit vectors, plus the FSM state encoding and sign helpers.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

package Types;

  localparam int IN_FRAC  = 8;
  localparam int OUT_FRAC = 14;
  localparam int COMP_W   = 16;
  // Square root of a sum of Q8.8 squares (16 fraction bits) lands back in Q8.8.
  localparam int MAG_FRAC = IN_FRAC;

  typedef struct packed {
    logic [`TAG_SIZE-1:0] tag;
    logic [COMP_W-1:0]    x;
    logic [COMP_W-1:0]    y;
    logic [COMP_W-1:0]    z;
  } TaggedVector;

  typedef struct packed {
    logic [`TAG_SIZE-1:0] tag;
    logic [COMP_W-1:0]    x;
    logic [COMP_W-1:0]    y;
    logic [COMP_W-1:0]    z;
  } TaggedNormalized;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUMSQ,
    ST_SQRT,
    ST_DIV,
    ST_OUT
  } norm_state_e;

  // Magnitude of a two's-complement component; 0x8000 maps to 32768 unsigned.
  function automatic logic [COMP_W-1:0] abs16(input logic [COMP_W-1:0] v);
    return v[COMP_W-1] ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [COMP_W-1:0] apply_sign(input logic [COMP_W-2:0] q,
                                                   input logic              neg);
    logic [COMP_W-1:0] v;
    v = {1'b0, q};
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring serial divider producing Q_W quotient bits, one per cycle. The caller
// guarantees dividend >> Q_W < divisor, so the quotient fits in Q_W bits.
module seq_divider #(
  parameter int DVD_W = 30,
  parameter int DVS_W = 16,
  parameter int Q_W   = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int CNT_W = $clog2(Q_W);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DVS_W-1:0] rem_q;
  logic [DVS_W-1:0] dvs_q;
  logic [Q_W-1:0]   dvd_q;
  logic [Q_W-1:0]   quo_q;

  logic             load;
  logic [DVS_W-1:0] rem_src;
  logic [DVS_W-1:0] dvs_src;
  logic [Q_W-1:0]   dvd_src;
  logic [DVS_W:0]   shifted;
  logic             fits;
  logic [DVS_W-1:0] rem_nxt;

  // The start cycle already performs the first iteration straight from the inputs.
  assign load = start_i && !busy_q;

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch can form.
  always_comb begin
    rem_src = load ? DVS_W'(dividend_i[DVD_W-1:Q_W]) : rem_q;
    dvd_src = load ? dividend_i[Q_W-1:0] : dvd_q;
    dvs_src = load ? divisor_i : dvs_q;
    shifted = {rem_src, dvd_src[Q_W-1]};
    fits    = shifted >= {1'b0, dvs_src};
    rem_nxt = fits ? DVS_W'(shifted - {1'b0, dvs_src}) : shifted[DVS_W-1:0];
  end

  // NOTE: sequential state uses non-blocking '<=' so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      dvd_q  <= '0;
      quo_q  <= '0;
    end else if (load) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(1);
      rem_q  <= rem_nxt;
      dvs_q  <= divisor_i;
      dvd_q  <= dvd_src << 1;
      quo_q  <= Q_W'(fits);
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      rem_q <= rem_nxt;
      dvd_q <= dvd_q << 1;
      quo_q <= {quo_q[Q_W-2:0], fits};
      if (cnt_q == CNT_W'(Q_W - 1)) busy_q <= 1'b0;
    end
  end

  assign busy_o     = busy_q;
  // High during the final iteration; the quotient is complete after this edge.
  assign done_o     = busy_q && (cnt_q == CNT_W'(Q_W - 1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/tagged_vec_normalizer.sv
// Normalizes a tagged signed Q8.8 (x,y,z) vector to unit length in Q1.14, one vector in flight.
// Optional zero-vector event counter and zero_count port when NORM_ZERO_CNT_EN is defined.
module tagged_vec_normalizer
  import Types::*;
#(
  parameter int TAG_SIZE = `TAG_SIZE,
  parameter int FRAC_OUT = OUT_FRAC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  TaggedVector     tagged_vector_in,
  output logic            out_valid,
  input  logic            out_ready,
  output TaggedNormalized tagged_normalized_out
`ifdef NORM_ZERO_CNT_EN
  ,
  output logic [15:0]     zero_count
`endif
);

  localparam int DIV_SHIFT = FRAC_OUT + MAG_FRAC - IN_FRAC;
  localparam int Q_W       = FRAC_OUT + 1;
  localparam int DVD_W     = COMP_W + DIV_SHIFT;
  localparam int SUM_W     = 2 * COMP_W;
  localparam int REM_W     = COMP_W + 1;
  localparam int SQRT_ITER = COMP_W;
  localparam int IT_W      = $clog2(SQRT_ITER);

  norm_state_e         state_q, state_d;
  logic [TAG_SIZE-1:0] tag_q;
  logic [COMP_W-1:0]   abs_q [3];
  logic [2:0]          neg_q;
  logic                zero_q;
  logic [SUM_W-1:0]    rad_q;
  logic [REM_W-1:0]    rem_q;
  logic [COMP_W-1:0]   root_q;
  logic [IT_W-1:0]     sqrt_it_q;

  logic                accept;
  logic                div_start;
  logic [2:0]          div_busy;
  logic [2:0]          div_done;
  logic [Q_W-1:0]      quo [3];
  logic [SUM_W-1:0]    sum_sq;
  logic [REM_W+1:0]    rem_sh;
  logic [REM_W+1:0]    trial;
  logic                root_bit;
  logic [REM_W-1:0]    rem_nxt;

  assign accept = in_valid && in_ready;
  assign sum_sq = SUM_W'(abs_q[0]) * SUM_W'(abs_q[0])
                + SUM_W'(abs_q[1]) * SUM_W'(abs_q[1])
                + SUM_W'(abs_q[2]) * SUM_W'(abs_q[2]);

  // One restoring square-root step: two radicand bits in, one root bit out.
  always_comb begin
    rem_sh   = {rem_q, rad_q[SUM_W-1 -: 2]};
    trial    = {1'b0, root_q, 2'b01};
    root_bit = rem_sh >= trial;
    rem_nxt  = root_bit ? REM_W'(rem_sh - trial) : rem_sh[REM_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    div_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SUMSQ;
      end
      ST_SUMSQ: state_d = (sum_sq == '0) ? ST_OUT : ST_SQRT;
      ST_SQRT: begin
        if (sqrt_it_q == IT_W'(SQRT_ITER - 1)) state_d = ST_DIV;
      end
      ST_DIV: begin
        div_start = ~|div_busy;
        if (&div_done) state_d = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: these are a handful of flops, not a memory, so clearing them on reset is cheap and keeps state defined.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q     <= '0;
      neg_q     <= '0;
      zero_q    <= 1'b0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      sqrt_it_q <= '0;
      for (int i = 0; i < 3; i++) abs_q[i] <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            tag_q    <= tagged_vector_in.tag;
            abs_q[0] <= abs16(tagged_vector_in.x);
            abs_q[1] <= abs16(tagged_vector_in.y);
            abs_q[2] <= abs16(tagged_vector_in.z);
            neg_q    <= {tagged_vector_in.z[COMP_W-1], tagged_vector_in.y[COMP_W-1],
                         tagged_vector_in.x[COMP_W-1]};
          end
        end
        ST_SUMSQ: begin
          rad_q     <= sum_sq;
          rem_q     <= '0;
          root_q    <= '0;
          sqrt_it_q <= '0;
          zero_q    <= (sum_sq == '0);
        end
        ST_SQRT: begin
          rad_q     <= rad_q << 2;
          rem_q     <= rem_nxt;
          root_q    <= {root_q[COMP_W-2:0], root_bit};
          sqrt_it_q <= sqrt_it_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // |c| <= mag always holds, so each quotient is at most 1.0 (0x4000) and fits in Q_W bits.
  for (genvar i = 0; i < 3; i++) begin : g_div
    logic [DVD_W-1:0] dividend;
    assign dividend = DVD_W'(abs_q[i]) << DIV_SHIFT;

    seq_divider #(
      .DVD_W (DVD_W),
      .DVS_W (COMP_W),
      .Q_W   (Q_W)
    ) u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_i    (div_start),
      .dividend_i (dividend),
      .divisor_i  (root_q),
      .busy_o     (div_busy[i]),
      .done_o     (div_done[i]),
      .quotient_o (quo[i])
    );
  end

  always_comb begin
    tagged_normalized_out = '0;
    if (state_q == ST_OUT) begin
      tagged_normalized_out.tag = tag_q;
      if (!zero_q) begin
        tagged_normalized_out.x = apply_sign(quo[0], neg_q[0]);
        tagged_normalized_out.y = apply_sign(quo[1], neg_q[1]);
        tagged_normalized_out.z = apply_sign(quo[2], neg_q[2]);
      end
    end
  end

`ifdef NORM_ZERO_CNT_EN
  logic [15:0] zero_cnt_q;
  logic        vec_zero;

  assign vec_zero = ~|{tagged_vector_in.x, tagged_vector_in.y, tagged_vector_in.z};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        zero_cnt_q <= '0;
    else if (accept && vec_zero && zero_cnt_q != 16'hFFFF) zero_cnt_q <= zero_cnt_q + 1'b1;
  end

  assign zero_count = zero_cnt_q;
`endif

endmodule

// File: doc/tagged_vec_normalizer.md
TAGGED_VEC_NORMALIZER -- requirements
Module: tagged_vec_normalizer

Interface
REQ-001 SHALL have parameter TAG_SIZE, default `TAG_SIZE, giving the tag width carried through unchanged.
REQ-002 SHALL have parameter FRAC_OUT, default 14, giving the output fraction bits; only 14 is supported.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream offers a vector.
REQ-006 SHALL have port in_ready, output, 1, block accepts a vector this cycle.
REQ-007 SHALL have port tagged_vector_in, input, TaggedVector, tag plus signed 16-bit Q8.8 x/y/z.
REQ-008 SHALL have port out_valid, output, 1, normalized result available.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes (tagged normalized FIFO write side, driven from !FIFO-full).
REQ-010 SHALL have port tagged_normalized_out, output, TaggedNormalized, tag plus signed 16-bit Q1.14 x/y/z.
REQ-011 SHALL have port zero_count, output, 16, zero-vector event count; present only with NORM_ZERO_CNT_EN.

Function
REQ-012 SHALL implement FSM IDLE -> SUMSQ -> SQRT -> DIV -> OUT -> IDLE, one vector in flight.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready, latching tag and components.
REQ-014 SUMSQ (1 cycle) SHALL compute s = x²+y²+z² as unsigned 32-bit, no overflow possible.
REQ-015 SQRT (16 cycles, bit-serial restoring) SHALL produce mag = floor(sqrt(s)), unsigned 16-bit, Q8.8.
REQ-016 DIV (15 cycles, three parallel restoring dividers) SHALL compute q = floor((|c| << 14) / mag) per component.
REQ-017 Result sign SHALL be the input component sign, applied by two's-complement negation after division; q=16384 with positive sign is emitted as 16384 (0x4000).
REQ-018 Latency from accept to out_valid rising SHALL be exactly 33 cycles.
REQ-019 If s == 0, the block SHALL skip SQRT/DIV, go SUMSQ -> OUT, and emit x=y=z=0 with latched tag (latency 2).
REQ-020 In OUT, out_valid=1 and tagged_normalized_out SHALL hold stable until out_ready=1; the transfer occurs on out_valid && out_ready; next state IDLE.
REQ-021 A new vector SHALL NOT be accepted in the same cycle as the output transfer (in_ready asserts the cycle after).
REQ-022 Tag SHALL pass through bit-exact; no tag reordering.

Reset
REQ-023 On reset_n=0, asynchronously: state=IDLE, in_ready=1 after reset release, out_valid=0, tagged_normalized_out=0, zero_count=0, all datapath registers 0.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight vector; no partial output is produced.

Configuration
REQ-025 Macro NORM_ZERO_CNT_EN defined: the zero_count port exists and increments by 1 on each accepted zero vector, saturating at 0xFFFF.
REQ-026 Macro NORM_ZERO_CNT_EN undefined: no zero_count port or counter; zero vectors still emit a zero result per REQ-019.

Structure
REQ-027 TaggedVector, TaggedNormalized, `TAG_SIZE and the Q-format constants (IN_FRAC=8, OUT_FRAC=14) SHALL live in the shared Types.sv package.
REQ-028 The serial divider SHALL be a sub-module seq_divider (start, busy/done, 15-iteration restoring), instantiated three times; sqrt stays inline.

Verification
REQ-029 (x,y,z)=(0x0300,0x0400,0x0000), tag=5, out_ready=1 -> after 33 cycles out=(0x2666,0x3333,0x0000), tag=5.
REQ-030 (-3.0,0,4.0)=(0xFD00,0x0000,0x0400) -> out=(0xD99A,0x0000,0x3333).
REQ-031 (0,0,-1.0)=(0,0,0xFF00) -> out z=0xC000, x=y=0; (1.0,0,0) -> x=0x4000.
REQ-032 Zero vector, tag=9 -> out all zero, tag=9, 2-cycle latency, zero_count 0->1 (macro on).
REQ-033 out_ready held 0 for 10 cycles in OUT -> output stable, in_ready=0 throughout; out_ready=1 -> one transfer, in_ready=1 next cycle.
REQ-034 reset_n pulsed low at cycle 10 of SQRT -> out_valid stays 0, next vector (3,4,0) yields correct result with correct latency.
